// File: rtl/decode_pkg.sv
// Shared definitions for the RISC-V decode stage: opcode and funct7
// constants, ALU control / operand-source encodings, the skid-buffer state
// type and the decoded-control payload carried through the buffer.
package decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [5:0] F6_BASE   = 6'b000000;
  localparam logic [5:0] F6_ALT    = 6'b010000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRC_RS2    = 2'b00,
    SRC_IMM    = 2'b01,
    SRC_PC_IMM = 2'b10
  } alu_src_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_HALF  = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

  // Decoded control; the immediate travels separately at XLEN width.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    alu_ctrl_e        alu_ctrl;
    alu_src_e         alu_src;
    logic [2:0]       br_func;
    logic [2:0]       mem_size;
    logic             we;
    logic             branch;
    logic             jump;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             word_op;
    logic             muldiv;
    logic [2:0]       md_op;
    logic             illegal;
  } ctrl_t;

  // Base (funct7 = 0) ALU operation selected directly by funct3.
  function automatic alu_ctrl_e alu_base(input logic [2:0] funct3);
    return alu_ctrl_e'({1'b0, funct3});
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I/RV64I decoder: instruction word -> control
// struct plus sign-extended immediate.
// Optional feature macro: DECODE_MEXT_EN enables M-extension decode.
// Ports:
//   instr_i  32-bit instruction word
//   ctrl_o   decoded control (register indices, ALU/memory/branch control)
//   imm_o    XLEN-wide sign-extended immediate (0 for R-type)
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter bit          SUPPRESS_X0_WE = 1'b1
) (
  input  logic [INSTR_W-1:0] instr_i,
  output ctrl_t              ctrl_o,
  output logic [XLEN-1:0]    imm_o
);

  localparam bit IS_RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            sh_base, sh_alt;
  logic            illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = XLEN'($signed(instr_i[31:20]));
  assign imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_b = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                instr_i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr_i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                instr_i[30:21], 1'b0}));

  // RV64 shift-immediates have a 6-bit shamt, so only funct6 is checked.
  assign sh_base = IS_RV64 ? (instr_i[31:26] == F6_BASE) : (funct7 == F7_BASE);
  assign sh_alt  = IS_RV64 ? (instr_i[31:26] == F6_ALT)  : (funct7 == F7_ALT);

  always_comb begin
    ctrl_o     = '0;
    imm_o      = '0;
    illegal    = 1'b0;
    ctrl_o.rd  = instr_i[11:7];
    ctrl_o.rs1 = instr_i[19:15];
    ctrl_o.rs2 = instr_i[24:20];

    case (opcode)
      OPC_OP: begin
        ctrl_o.we = 1'b1;
        if (funct7 == F7_BASE) begin
          ctrl_o.alu_ctrl = alu_base(funct3);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          ctrl_o.alu_ctrl = alu_ctrl_e'({1'b1, funct3});
`ifdef DECODE_MEXT_EN
        end else if (funct7 == F7_MULDIV) begin
          ctrl_o.muldiv   = 1'b1;
          ctrl_o.md_op    = funct3;
          ctrl_o.alu_ctrl = ALU_ADD;
`endif
        end else begin
          illegal = 1'b1;
        end
      end

      OPC_OP_32: begin
        ctrl_o.we      = 1'b1;
        ctrl_o.word_op = 1'b1;
        if (!IS_RV64) begin
          illegal = 1'b1;
        end else if (funct7 == F7_BASE &&
                     (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) begin
          ctrl_o.alu_ctrl = alu_base(funct3);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          ctrl_o.alu_ctrl = alu_ctrl_e'({1'b1, funct3});
`ifdef DECODE_MEXT_EN
        end else if (funct7 == F7_MULDIV && (funct3 == 3'b000 || funct3[2])) begin
          ctrl_o.muldiv   = 1'b1;
          ctrl_o.md_op    = funct3;
          ctrl_o.alu_ctrl = ALU_ADD;
`endif
        end else begin
          illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        imm_o          = imm_i;
        ctrl_o.alu_src = SRC_IMM;
        ctrl_o.we      = 1'b1;
        case (funct3)
          3'b001: begin
            ctrl_o.alu_ctrl = ALU_SLL;
            illegal         = !sh_base;
          end
          3'b101: begin
            ctrl_o.alu_ctrl = sh_alt ? ALU_SRA : ALU_SRL;
            illegal         = !(sh_base || sh_alt);
          end
          default: ctrl_o.alu_ctrl = alu_base(funct3);
        endcase
      end

      OPC_OP_IMM_32: begin
        imm_o          = imm_i;
        ctrl_o.alu_src = SRC_IMM;
        ctrl_o.we      = 1'b1;
        ctrl_o.word_op = 1'b1;
        case (funct3)
          3'b000: ctrl_o.alu_ctrl = ALU_ADD;
          3'b001: begin
            ctrl_o.alu_ctrl = ALU_SLL;
            illegal         = (funct7 != F7_BASE);
          end
          3'b101: begin
            ctrl_o.alu_ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            illegal         = !(funct7 == F7_BASE || funct7 == F7_ALT);
          end
          default: illegal = 1'b1;
        endcase
        if (!IS_RV64) illegal = 1'b1;
      end

      OPC_LOAD: begin
        imm_o             = imm_i;
        ctrl_o.alu_src    = SRC_IMM;
        ctrl_o.we         = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.mem_size   = funct3;
        illegal = (funct3 == 3'b111) ||
                  (!IS_RV64 && (funct3 == 3'b011 || funct3 == 3'b110));
      end

      OPC_STORE: begin
        imm_o            = imm_s;
        ctrl_o.alu_src   = SRC_IMM;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.mem_size  = funct3;
        illegal = (funct3 > (IS_RV64 ? 3'd3 : 3'd2));
      end

      OPC_BRANCH: begin
        imm_o           = imm_b;
        ctrl_o.branch   = 1'b1;
        ctrl_o.alu_ctrl = ALU_SUB;
        ctrl_o.br_func  = funct3;
        illegal = (funct3 == 3'b010 || funct3 == 3'b011);
      end

      OPC_JAL: begin
        imm_o          = imm_j;
        ctrl_o.alu_src = SRC_PC_IMM;
        ctrl_o.jump    = 1'b1;
        ctrl_o.we      = 1'b1;
      end

      OPC_JALR: begin
        imm_o          = imm_i;
        ctrl_o.alu_src = SRC_IMM;
        ctrl_o.jump    = 1'b1;
        ctrl_o.we      = 1'b1;
      end

      OPC_LUI: begin
        imm_o          = imm_u;
        ctrl_o.alu_src = SRC_IMM;
        ctrl_o.we      = 1'b1;
        ctrl_o.rs1     = '0;
      end

      OPC_AUIPC: begin
        imm_o          = imm_u;
        ctrl_o.alu_src = SRC_PC_IMM;
        ctrl_o.we      = 1'b1;
      end

      default: illegal = 1'b1;
    endcase

    if (instr_i[1:0] != 2'b11) illegal = 1'b1;

    // Illegal encodings must not have architectural side effects.
    if (illegal) begin
      ctrl_o.we         = 1'b0;
      ctrl_o.branch     = 1'b0;
      ctrl_o.jump       = 1'b0;
      ctrl_o.mem_read   = 1'b0;
      ctrl_o.mem_write  = 1'b0;
      ctrl_o.mem_to_reg = 1'b0;
      ctrl_o.muldiv     = 1'b0;
    end
    ctrl_o.illegal = illegal;

    if (SUPPRESS_X0_WE && ctrl_o.rd == '0) ctrl_o.we = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RISC-V decode stage with a two-entry skid buffer
// (main output register + skid register) and synchronous flush.
// Optional feature macro: DECODE_MEXT_EN (M-extension decode, in decode_comb).
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   in_valid_i / in_ready_o, in_instr_i, in_pc_i      upstream
//   out_valid_o / out_ready_i, out_pc_o, out_rd_o, out_rs1_o, out_rs2_o,
//   out_imm_o, out_alu_ctrl_o, out_alu_src_o, out_br_func_o, out_mem_size_o,
//   out_we_o, out_branch_o, out_jump_o, out_mem_read_o, out_mem_write_o,
//   out_mem_to_reg_o, out_word_op_o, out_muldiv_o, out_md_op_o,
//   out_illegal_o                                     downstream
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter bit          SUPPRESS_X0_WE = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] in_instr_i,
  input  logic [XLEN-1:0]    in_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    out_pc_o,
  output logic [REG_W-1:0]   out_rd_o,
  output logic [REG_W-1:0]   out_rs1_o,
  output logic [REG_W-1:0]   out_rs2_o,
  output logic [XLEN-1:0]    out_imm_o,
  output logic [3:0]         out_alu_ctrl_o,
  output logic [1:0]         out_alu_src_o,
  output logic [2:0]         out_br_func_o,
  output logic [2:0]         out_mem_size_o,
  output logic               out_we_o,
  output logic               out_branch_o,
  output logic               out_jump_o,
  output logic               out_mem_read_o,
  output logic               out_mem_write_o,
  output logic               out_mem_to_reg_o,
  output logic               out_word_op_o,
  output logic               out_muldiv_o,
  output logic [2:0]         out_md_op_o,
  output logic               out_illegal_o
);

  ctrl_t           dec_ctrl_d;
  logic [XLEN-1:0] dec_imm_d;

  buf_state_e      state_q;
  logic            in_ready_q, out_valid_q;
  ctrl_t           main_ctrl_q, skid_ctrl_q;
  logic [XLEN-1:0] main_imm_q, skid_imm_q;
  logic [XLEN-1:0] main_pc_q, skid_pc_q;
  logic            accept;

  decode_comb #(
    .XLEN          (XLEN),
    .SUPPRESS_X0_WE(SUPPRESS_X0_WE)
  ) u_decode_comb (
    .instr_i(in_instr_i),
    .ctrl_o (dec_ctrl_d),
    .imm_o  (dec_imm_d)
  );

  assign accept = in_valid_i && in_ready_q;

  // Skid-buffer FSM; main register always holds the oldest entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      main_imm_q  <= '0;
      main_pc_q   <= '0;
      skid_ctrl_q <= '0;
      skid_imm_q  <= '0;
      skid_pc_q   <= '0;
    end else if (flush_i) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            main_ctrl_q <= dec_ctrl_d;
            main_imm_q  <= dec_imm_d;
            main_pc_q   <= in_pc_i;
            out_valid_q <= 1'b1;
            state_q     <= BUF_HALF;
          end
        end
        BUF_HALF: begin
          if (accept && out_ready_i) begin
            main_ctrl_q <= dec_ctrl_d;
            main_imm_q  <= dec_imm_d;
            main_pc_q   <= in_pc_i;
          end else if (accept) begin
            skid_ctrl_q <= dec_ctrl_d;
            skid_imm_q  <= dec_imm_d;
            skid_pc_q   <= in_pc_i;
            in_ready_q  <= 1'b0;
            state_q     <= BUF_FULL;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (out_ready_i) begin
            main_ctrl_q <= skid_ctrl_q;
            main_imm_q  <= skid_imm_q;
            main_pc_q   <= skid_pc_q;
            in_ready_q  <= 1'b1;
            state_q     <= BUF_HALF;
          end
        end
        default: begin
          state_q     <= BUF_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o       = in_ready_q;
  assign out_valid_o      = out_valid_q;
  assign out_pc_o         = main_pc_q;
  assign out_imm_o        = main_imm_q;
  assign out_rd_o         = main_ctrl_q.rd;
  assign out_rs1_o        = main_ctrl_q.rs1;
  assign out_rs2_o        = main_ctrl_q.rs2;
  assign out_alu_ctrl_o   = main_ctrl_q.alu_ctrl;
  assign out_alu_src_o    = main_ctrl_q.alu_src;
  assign out_br_func_o    = main_ctrl_q.br_func;
  assign out_mem_size_o   = main_ctrl_q.mem_size;
  assign out_we_o         = main_ctrl_q.we;
  assign out_branch_o     = main_ctrl_q.branch;
  assign out_jump_o       = main_ctrl_q.jump;
  assign out_mem_read_o   = main_ctrl_q.mem_read;
  assign out_mem_write_o  = main_ctrl_q.mem_write;
  assign out_mem_to_reg_o = main_ctrl_q.mem_to_reg;
  assign out_word_op_o    = main_ctrl_q.word_op;
  assign out_muldiv_o     = main_ctrl_q.muldiv;
  assign out_md_op_o      = main_ctrl_q.md_op;
  assign out_illegal_o    = main_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (XLEN=32, SUPPRESS_X0_WE=1).
module tb_decode_stage;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic            in_ready_o, out_valid_o;
  logic [XLEN-1:0] out_pc_o, out_imm_o;
  logic [4:0]      out_rd_o, out_rs1_o, out_rs2_o;
  logic [3:0]      out_alu_ctrl_o;
  logic [1:0]      out_alu_src_o;
  logic [2:0]      out_br_func_o, out_mem_size_o, out_md_op_o;
  logic            out_we_o, out_branch_o, out_jump_o, out_mem_read_o;
  logic            out_mem_write_o, out_mem_to_reg_o, out_word_op_o;
  logic            out_muldiv_o, out_illegal_o;

  decode_stage #(.XLEN(XLEN), .SUPPRESS_X0_WE(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .out_pc_o(out_pc_o), .out_rd_o(out_rd_o), .out_rs1_o(out_rs1_o),
    .out_rs2_o(out_rs2_o), .out_imm_o(out_imm_o),
    .out_alu_ctrl_o(out_alu_ctrl_o), .out_alu_src_o(out_alu_src_o),
    .out_br_func_o(out_br_func_o), .out_mem_size_o(out_mem_size_o),
    .out_we_o(out_we_o), .out_branch_o(out_branch_o), .out_jump_o(out_jump_o),
    .out_mem_read_o(out_mem_read_o), .out_mem_write_o(out_mem_write_o),
    .out_mem_to_reg_o(out_mem_to_reg_o), .out_word_op_o(out_word_op_o),
    .out_muldiv_o(out_muldiv_o), .out_md_op_o(out_md_op_o),
    .out_illegal_o(out_illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic [2:0]  brf, msz, mdop;
    logic        we, br, jmp, mr, mw, m2r, wop, md, ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] pc_cnt = 32'h0000_1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference decode from the RV32I field layout and legality rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t r;
    logic signed [31:0] si;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    si  = $signed(ins);
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    imm_i = 32'(si >>> 20);
    imm_s = (32'(si >>> 20) & 32'hFFFF_FFE0) | {27'b0, ins[11:7]};
    imm_b = (32'(si >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11) |
            (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    imm_u = ins & 32'hFFFF_F000;
    imm_j = (32'(si >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000) |
            (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    r = '{default: '0};
    r.pc = pc; r.rd = ins[11:7]; r.rs1 = ins[19:15]; r.rs2 = ins[24:20];
    case (opc)
      7'b0110011: begin
        r.we = 1;
        if (f7 == 7'h00) r.alu = {1'b0, f3};
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) r.alu = {1'b1, f3};
`ifdef DECODE_MEXT_EN
        else if (f7 == 7'h01) begin r.md = 1; r.mdop = f3; r.alu = 4'b0000; end
`endif
        else r.ill = 1;
      end
      7'b0010011: begin
        r.imm = imm_i; r.src = 2'b01; r.we = 1; r.alu = {1'b0, f3};
        if (f3 == 3'd1 && f7 != 7'h00) r.ill = 1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) r.alu = 4'b1101;
          else if (f7 != 7'h00) r.ill = 1;
        end
      end
      7'b0000011: begin
        r.imm = imm_i; r.src = 2'b01; r.we = 1; r.mr = 1; r.m2r = 1; r.msz = f3;
        r.ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'b0100011: begin
        r.imm = imm_s; r.src = 2'b01; r.mw = 1; r.msz = f3; r.ill = (f3 > 3'd2);
      end
      7'b1100011: begin
        r.imm = imm_b; r.br = 1; r.alu = 4'b1000; r.brf = f3;
        r.ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'b1101111: begin r.imm = imm_j; r.src = 2'b10; r.jmp = 1; r.we = 1; end
      7'b1100111: begin r.imm = imm_i; r.src = 2'b01; r.jmp = 1; r.we = 1; end
      7'b0110111: begin r.imm = imm_u; r.src = 2'b01; r.we = 1; r.rs1 = 0; end
      7'b0010111: begin r.imm = imm_u; r.src = 2'b10; r.we = 1; end
      default: r.ill = 1;
    endcase
    if (r.ill) begin
      r.we = 0; r.br = 0; r.jmp = 0; r.mr = 0; r.mw = 0; r.m2r = 0; r.md = 0;
    end
    if (r.rd == 5'd0) r.we = 0;
    return r;
  endfunction

  function automatic logic [31:0] gen();
    logic [6:0] opc_tab [11];
    logic [6:0] f7_tab [4];
    logic [31:0] r;
    opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0011011,
                7'b0111011};
    f7_tab = '{7'h00, 7'h20, 7'h01, 7'h7f};
    r = $urandom;
    if ($urandom_range(0, 15) < 14) r[6:0] = opc_tab[$urandom_range(0, 10)];
    if ($urandom_range(0, 1) == 1) r[31:25] = f7_tab[$urandom_range(0, 3)];
    return r;
  endfunction

  // Monitor: occupancy checks, output compare, and push on accept.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("out_valid", 64'(out_valid_o), 64'(exp_q.size() > 0));
      chk("in_ready", 64'(in_ready_o), 64'(exp_q.size() < 2));
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid_o && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'(out_valid_o), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("pc", 64'(out_pc_o), 64'(e.pc));
            chk("illegal", 64'(out_illegal_o), 64'(e.ill));
            chk("we", 64'(out_we_o), 64'(e.we));
            chk("branch", 64'(out_branch_o), 64'(e.br));
            chk("jump", 64'(out_jump_o), 64'(e.jmp));
            chk("mem_read", 64'(out_mem_read_o), 64'(e.mr));
            chk("mem_write", 64'(out_mem_write_o), 64'(e.mw));
            chk("mem_to_reg", 64'(out_mem_to_reg_o), 64'(e.m2r));
            chk("muldiv", 64'(out_muldiv_o), 64'(e.md));
            if (!e.ill) begin
              chk("rd", 64'(out_rd_o), 64'(e.rd));
              chk("rs1", 64'(out_rs1_o), 64'(e.rs1));
              chk("rs2", 64'(out_rs2_o), 64'(e.rs2));
              chk("imm", 64'(out_imm_o), 64'(e.imm));
              chk("alu_ctrl", 64'(out_alu_ctrl_o), 64'(e.alu));
              chk("alu_src", 64'(out_alu_src_o), 64'(e.src));
              chk("br_func", 64'(out_br_func_o), 64'(e.brf));
              chk("mem_size", 64'(out_mem_size_o), 64'(e.msz));
              chk("word_op", 64'(out_word_op_o), 64'(e.wop));
              chk("md_op", 64'(out_md_op_o), 64'(e.mdop));
            end
          end
        end
        if (in_valid && in_ready_o) exp_q.push_back(model(in_instr, in_pc));
      end
    end
  end

  task automatic send(input logic [31:0] ins);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc_cnt;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    pc_cnt   = pc_cnt + 32'd4;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready_o), 64'd1);
    chk({tag, "_pc"}, 64'(out_pc_o), 64'd0);
    chk({tag, "_imm"}, 64'(out_imm_o), 64'd0);
    chk({tag, "_rd"}, 64'(out_rd_o), 64'd0);
    chk({tag, "_we"}, 64'(out_we_o), 64'd0);
    chk({tag, "_alu"}, 64'(out_alu_ctrl_o), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Directed decodes with downstream always ready
    out_ready = 1'b1;
    send(32'h002081B3);   // ADD x3,x1,x2
    send(32'h402081B3);   // SUB x3,x1,x2
    send(32'hFFF00093);   // ADDI x1,x0,-1
    send(32'h00208463);   // BEQ x1,x2,+8
    send(32'h027302B3);   // MUL x5,x6,x7
    send(32'h12345537);   // LUI x10
    send(32'h00000013);   // ADDI x0 (we suppressed)
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: three back-to-back, out_ready low for three cycles
    out_ready = 1'b0;
    send(32'h00A00513);
    send(32'h00B00593);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00C00613);
    repeat (3) @(posedge clk);
    #1;

    // Flush while FULL with a new instruction offered
    out_ready = 1'b0;
    send(32'h00D00693);
    send(32'h00E00713);
    in_valid = 1'b1;
    in_instr = 32'h00F00793;
    in_pc    = pc_cnt;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h01000813);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'h01100893);
    send(32'h01200913);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h002081B3);
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      #1;
    end

    // Drain
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
